// File: rtl/alu_bit_serial_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The master issues operations and the slave (the sequencer) returns status and results.
interface alu_bit_serial_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, op,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, a, b, op,
      output busy, done, result, cout, ovf
   );
endinterface

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer: drives an external 1-bit ALU cell LSB first, one bit per clock,
// and accumulates the result, final carry and signed overflow.
module alu_bit_serial_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   alu_bit_serial_seq_if.slave bus,
   output logic alu_a,
   output logic alu_b,
   output logic alu_cin,
   output logic alu_f1,
   output logic alu_f0,
   input  logic alu_res,
   input  logic alu_cout
);
   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] result_q;
   logic [1:0]       op_q;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cout_q;
   logic             ovf_q;
   logic             busy;
   logic             done;
   logic             last;
   logic             arith;
   logic             sub;

   assign arith = ~op_q[1];
   assign sub   = (op_q == 2'b01);
   assign last  = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      alu_a      = 1'b0;
      alu_b      = 1'b0;
      alu_cin    = 1'b0;
      alu_f1     = op_q[1];
      alu_f0     = op_q[0];
      res_next   = {alu_res, res_sh[WIDTH-1:1]};
      case (state)
         IDLE: begin
            if (bus.start) next_state = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            alu_a   = a_sh[0];
            // Subtraction is A + ~B + 1; the +1 comes from the preset carry.
            alu_b   = b_sh[0] ^ sub;
            alu_cin = carry;
            if (last) next_state = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         result_q <= '0;
         op_q     <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.b;
                  op_q  <= bus.op;
                  carry <= (bus.op == 2'b01);
                  cnt   <= '0;
               end
            end
            RUN: begin
               res_sh <= res_next;
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               carry  <= arith & alu_cout;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  result_q <= res_next;
                  cout_q   <= arith & alu_cout;
                  // Carry into the MSB differs from carry out of it on signed overflow.
                  ovf_q    <= arith & (carry ^ alu_cout);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed bench for the bit-serial ALU sequencer, closing the loop with a 1-bit ALU cell model.
module tb_alu_bit_serial_seq;
   localparam int unsigned W  = 8;
   localparam int unsigned W2 = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   alu_bit_serial_seq_if #(.WIDTH(W))  bus ();
   alu_bit_serial_seq_if #(.WIDTH(W2)) bus2 ();

   logic alu_a, alu_b, alu_cin, alu_f1, alu_f0, alu_res, alu_cout;
   logic c2_a, c2_b, c2_cin, c2_f1, c2_f0, c2_res, c2_cout;

   alu_bit_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_f1(alu_f1), .alu_f0(alu_f0),
      .alu_res(alu_res), .alu_cout(alu_cout)
   );

   alu_bit_serial_seq #(.WIDTH(W2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .alu_a(c2_a), .alu_b(c2_b), .alu_cin(c2_cin), .alu_f1(c2_f1), .alu_f0(c2_f0),
      .alu_res(c2_res), .alu_cout(c2_cout)
   );

   // 1-bit ALU cell: F=00/01 full adder, 10 AND, 11 OR; carry only meaningful for arithmetic.
   assign alu_res  = alu_f1 ? (alu_f0 ? (alu_a | alu_b) : (alu_a & alu_b)) : (alu_a ^ alu_b ^ alu_cin);
   assign alu_cout = alu_f1 ? 1'b0 : ((alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b)));
   assign c2_res   = c2_f1 ? (c2_f0 ? (c2_a | c2_b) : (c2_a & c2_b)) : (c2_a ^ c2_b ^ c2_cin);
   assign c2_cout  = c2_f1 ? 1'b0 : ((c2_a & c2_b) | (c2_cin & (c2_a ^ c2_b)));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] er, input logic ec, input logic eo);
      int unsigned edges;
      @(negedge clk);
      bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
      @(posedge clk); #1;
      edges = 1;
      bus.start = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      while (!bus.done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      check({tag, "_lat"},  edges, W + 1);
      check({tag, "_res"},  32'(bus.result), 32'(er));
      check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
      check({tag, "_ovf"},  32'(bus.ovf), 32'(eo));
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_idle"},  32'(bus.busy), 32'd0);
      check({tag, "_fop"},   32'({alu_f1, alu_f0}), 32'(op));
      check({tag, "_abc0"},  32'({alu_a, alu_b, alu_cin}), 32'd0);
      check({tag, "_hold"},  32'(bus.result), 32'(er));
   endtask

   initial begin
      int unsigned edges;
      int unsigned pulses;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
      bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.op = '0;
      #12;
      check("rst_state", 32'({bus.busy, bus.done, bus.cout, bus.ovf}), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_f1, alu_f0}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("add_5a_3c", 8'h5A, 8'h3C, 2'b00, 8'h96, 1'b0, 1'b1);
      run_op("sub_10_01", 8'h10, 8'h01, 2'b01, 8'h0F, 1'b1, 1'b0);
      run_op("sub_00_01", 8'h00, 8'h01, 2'b01, 8'hFF, 1'b0, 1'b0);
      run_op("sub_80_01", 8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b1);
      run_op("and_f0_3c", 8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, 1'b0);
      run_op("or_f0_0c",  8'hF0, 8'h0C, 2'b11, 8'hFC, 1'b0, 1'b0);

      // start held high with operands changing every cycle
      @(negedge clk);
      bus.a = 8'hFF; bus.b = 8'h01; bus.op = 2'b00; bus.start = 1'b1;
      @(posedge clk); #1;
      edges = 1;
      while (!bus.done && edges < 40) begin
         bus.a = 8'(edges * 37);
         bus.b = 8'(edges * 91);
         bus.op = 2'(edges);
         @(posedge clk); #1;
         edges++;
      end
      check("hold_lat",  edges, W + 1);
      check("hold_res",  32'(bus.result), 32'h00);
      check("hold_cout", 32'(bus.cout), 32'd1);
      check("hold_ovf",  32'(bus.ovf), 32'd0);
      bus.a = 8'h01; bus.b = 8'h02; bus.op = 2'b00;
      @(posedge clk); #1;
      check("hold_idle", 32'(bus.busy), 32'd0);
      check("hold_keep", 32'(bus.result), 32'h00);
      @(posedge clk); #1;
      check("hold_accept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      edges = 1;
      while (!bus.done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      check("hold2_lat", edges, W + 1);
      check("hold2_res", 32'(bus.result), 32'h03);
      @(posedge clk); #1;

      // asynchronous reset during bit 3
      @(negedge clk);
      bus.a = 8'h0F; bus.b = 8'h08; bus.op = 2'b00; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("rst_bit3_a", 32'(alu_a), 32'd1);
      rst = 1'b1;
      #1;
      check("arst_state",  32'({bus.busy, bus.done, bus.cout, bus.ovf}), 32'd0);
      check("arst_result", 32'(bus.result), 32'd0);
      check("arst_alu",    32'({alu_a, alu_b, alu_cin, alu_f1, alu_f0}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < int'(W) + 3; i++) begin
         @(posedge clk); #1;
         if (bus.done) pulses++;
      end
      check("arst_nodone", pulses, 0);
      run_op("add_01_01", 8'h01, 8'h01, 2'b00, 8'h02, 1'b0, 1'b0);

      // WIDTH=2 instance
      @(negedge clk);
      bus2.a = 2'b11; bus2.b = 2'b01; bus2.op = 2'b00; bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      edges = 1;
      while (!bus2.done && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      check("w2_lat",  edges, W2 + 1);
      check("w2_res",  32'(bus2.result), 32'd0);
      check("w2_cout", 32'(bus2.cout), 32'd1);
      check("w2_ovf",  32'(bus2.ovf), 32'd0);
      @(posedge clk); #1;
      check("w2_pulse", 32'(bus2.done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
